// File: rtl/fpu_pkg.sv
// Shared FPU definitions: normaliser state encoding and single-precision default widths.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } norm_state_t;

    localparam int unsigned DEF_MANT_W = 24;
    localparam int unsigned DEF_EXP_W  = 8;
    localparam int unsigned NIBBLES    = DEF_MANT_W / 4;

endpackage

// File: rtl/lzc_norm_seq_if.sv
// Operand/result handshake bundle for the sequential normaliser.
interface lzc_norm_seq_if
    import fpu_pkg::*;
#(
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned EXP_W  = DEF_EXP_W
);
    localparam int unsigned LZ_W = $clog2(MANT_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic [LZ_W-1:0]   out_lz;
    logic              out_zero;
    logic              out_uf;

    modport master (
        output in_valid, in_mant, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uf
    );

    modport slave (
        input  in_valid, in_mant, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_lz, out_zero, out_uf
    );

endinterface

// File: rtl/lzc_4.sv
// 4-bit leading-one detector slice: c = index of highest set bit, v = any bit set.
module lzc_4 (
    input  logic [3:0] nib,
    output logic [1:0] c,
    output logic       v
);

    always_comb begin
        v = |nib;
        c = 2'd0;
        if (nib[3])      c = 2'd3;
        else if (nib[2]) c = 2'd2;
        else if (nib[1]) c = 2'd1;
    end

endmodule

// File: rtl/lzc_norm_seq.sv
// Sequential mantissa normaliser: nibble-serial leading-zero scan through one shared
// lzc_4 slice, then a single-cycle barrel shift with exponent adjust and denormal clamp.
module lzc_norm_seq
    import fpu_pkg::*;
#(
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned EXP_W  = DEF_EXP_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    lzc_norm_seq_if.slave  bus
);

    localparam int unsigned LZ_W  = $clog2(MANT_W + 1);
    localparam int unsigned NIB_N = MANT_W / 4;
    localparam int unsigned NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

    norm_state_t state, state_nx;

    logic [MANT_W-1:0] mant_r;
    logic [EXP_W-1:0]  exp_r;
    logic [NIB_W-1:0]  nib_idx;
    logic [LZ_W-1:0]   lz_acc;

    logic [MANT_W-1:0] out_mant_r;
    logic [EXP_W-1:0]  out_exp_r;
    logic [LZ_W-1:0]   out_lz_r;
    logic              out_zero_r;
    logic              out_uf_r;

    logic [MANT_W-1:0] scan_word;
    logic [1:0]        nib_c;
    logic              nib_v;
    logic              last_nib;

    logic [EXP_W:0]    lz_ext;
    logic [EXP_W:0]    exp_ext;
    logic              clamp;
    logic [EXP_W:0]    shamt;
    logic [EXP_W-1:0]  exp_adj;

    // Bring the current nibble to the top so the slice always sees bits [MANT_W-1 -: 4].
    assign scan_word = mant_r << {nib_idx, 2'b00};
    assign last_nib  = (nib_idx == NIB_W'(NIB_N - 1));

    lzc_4 u_lzc (
        .nib (scan_word[MANT_W-1 -: 4]),
        .c   (nib_c),
        .v   (nib_v)
    );

    always_comb begin
        lz_ext  = (EXP_W + 1)'(lz_acc);
        exp_ext = {1'b0, exp_r};
        clamp   = !(lz_ext < exp_ext);
        exp_adj = EXP_W'(exp_ext - lz_ext);
        shamt   = lz_ext;
        if (clamp) begin
            shamt = (exp_r == '0) ? '0 : exp_ext - (EXP_W + 1)'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nx = SCAN;
            SCAN:    if (nib_v) state_nx = SHIFT;
                     else if (last_nib) state_nx = DONE;
            SHIFT:   state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mant_r     <= '0;
            exp_r      <= '0;
            nib_idx    <= '0;
            lz_acc     <= '0;
            out_mant_r <= '0;
            out_exp_r  <= '0;
            out_lz_r   <= '0;
            out_zero_r <= 1'b0;
            out_uf_r   <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mant_r  <= bus.in_mant;
                        exp_r   <= bus.in_exp;
                        nib_idx <= '0;
                        lz_acc  <= '0;
                    end
                end
                SCAN: begin
                    if (nib_v) begin
                        lz_acc <= lz_acc + LZ_W'(2'd3 - nib_c);
                    end else if (last_nib) begin
                        out_mant_r <= '0;
                        out_exp_r  <= '0;
                        out_lz_r   <= LZ_W'(MANT_W);
                        out_zero_r <= 1'b1;
                        out_uf_r   <= 1'b0;
                    end else begin
                        lz_acc  <= lz_acc + LZ_W'(4);
                        nib_idx <= nib_idx + NIB_W'(1);
                    end
                end
                SHIFT: begin
                    out_mant_r <= mant_r << shamt;
                    out_exp_r  <= clamp ? '0 : exp_adj;
                    out_lz_r   <= lz_acc;
                    out_zero_r <= 1'b0;
                    out_uf_r   <= clamp;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_mant  = out_mant_r;
    assign bus.out_exp   = out_exp_r;
    assign bus.out_lz    = out_lz_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_uf    = out_uf_r;

endmodule
